// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive deserializer.
package i2s_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W     = 6;
  localparam logic [SLOT_W-1:0] SLOT_MAX = 6'd63;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-stage synchronizer for one async I2S line, with a registered rising-edge flag.
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  // o_q is taken from r_prev so it lines up with o_rise across all instances.
  assign o_q    = r_prev;
  assign o_rise = r_rise;

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA on sys_clk and emits parallel samples.
//   state       | meaning
//   ST_UNLOCKED | after reset, waiting for the first LRCK change; no output
//   ST_LOCKED   | normal capture; left only through reset
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] au_data,
  output logic              ws,
  output logic              au_vld,
  output logic              frame_err,
  output logic              locked
);

  localparam logic [SLOT_W-1:0] L_LAST_SLOT = SLOT_W'(DATA_W);

  logic              w_bclk_unused;
  logic              w_bclk_rise;
  logic              w_lrck;
  logic              w_lrck_rise_unused;
  logic              w_sdata;
  logic              w_sdata_rise_unused;
  logic              w_change;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;

  lock_state_t       r_state;
  lock_state_t       w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic              r_lrck_q;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_au_data;
  logic              r_ws;
  logic              r_au_vld;
  logic              r_frame_err;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_d    (i2s_bclk),
    .o_q    (w_bclk_unused),
    .o_rise (w_bclk_rise)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_d    (i2s_lrck),
    .o_q    (w_lrck),
    .o_rise (w_lrck_rise_unused)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_d    (i2s_sdata),
    .o_q    (w_sdata),
    .o_rise (w_sdata_rise_unused)
  );

  assign w_change    = (w_lrck != r_lrck_q);
  assign w_slot_nxt  = (r_slot == SLOT_MAX) ? SLOT_MAX : r_slot + 1'b1;
  assign w_shreg_nxt = {r_shreg[DATA_W-2:0], w_sdata};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_UNLOCKED) && w_bclk_rise && w_change) begin
      w_state_nxt = ST_LOCKED;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_slot      <= '0;
      r_lrck_q    <= 1'b0;
      r_shreg     <= '0;
      r_au_data   <= '0;
      r_ws        <= CH_LEFT;
      r_au_vld    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_au_vld    <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_bclk_rise) begin
        if (w_change) begin
          // Slot 0 of the new channel is the I2S delay bit; any partial word is dropped.
          r_slot   <= '0;
          r_lrck_q <= w_lrck;
          r_shreg  <= '0;
          if ((r_state == ST_LOCKED) && (r_slot < L_LAST_SLOT)) begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_slot <= w_slot_nxt;
          if (w_slot_nxt <= L_LAST_SLOT) begin
            r_shreg <= w_shreg_nxt;
          end
          if ((w_slot_nxt == L_LAST_SLOT) && (r_state == ST_LOCKED)) begin
            r_au_data <= w_shreg_nxt;
            r_ws      <= r_lrck_q ? CH_RIGHT : CH_LEFT;
            r_au_vld  <= 1'b1;
          end
        end
      end
    end
  end

  assign au_data   = r_au_data;
  assign ws        = r_ws;
  assign au_vld    = r_au_vld;
  assign frame_err = r_frame_err;
  assign locked    = (r_state == ST_LOCKED);

endmodule

// File: doc/i2s_rx_deser.md
# i2s_rx_deser

I2S receive deserializer that turns the external ADC/codec serial stream (BCLK, LRCK, SDATA) into parallel 24-bit samples on `sys_clk`. It feeds the audio filter chain. It supplies the `au_data` word plus the `ws` channel flag that the FIR/equalizer path consumes, together with a one-cycle sample strobe. All I2S inputs are asynchronous. They are oversampled and synchronized inside the block.

## Interface
- `DATA_W`, 24: sample width captured per channel.
- `SYNC_STAGES`, 2: flip-flop stages on each async input (minimum 2).
- `sys_clk` in 1: 50 MHz system clock; every register lives in this domain.
- `sys_rst` in 1: reset, synchronous, active-high.
- `i2s_bclk` in 1: serial bit clock, async, ≤ `sys_clk`/4.
- `i2s_lrck` in 1: word select, async; 0 = left, 1 = right.
- `i2s_sdata` in 1: serial data, MSB first, standard I2S (one-BCLK delay after an LRCK edge).
- `au_data` out `DATA_W`: last completed sample, two's complement, held until the next completion.
- `ws` out 1: channel of `au_data`; 0 = left, 1 = right.
- `au_vld` out 1: one-cycle pulse when `au_data`/`ws` update.
- `frame_err` out 1: one-cycle pulse when a half-frame ends before `DATA_W` bits were captured.
- `locked` out 1: high once the first LRCK edge after reset has been seen.

## Operation
- **Input conditioning:**
  - `i2s_bclk`, `i2s_lrck` and `i2s_sdata` each pass through `SYNC_STAGES` flip-flops.
  - `bclk_rise` is asserted when the synchronized BCLK is 1 and its previous value was 0.
  - LRCK and SDATA are sampled only on `bclk_rise`.
- **Slot counter:**
  - `slot` is 6 bits and saturates at 63.
  - On a `bclk_rise` where the sampled LRCK differs from the stored `lrck_q`: `slot` ← 0 and `lrck_q` ← the new value.
  - Otherwise `slot` increments by 1.
- **Capture:**
  - Slot 0 is the I2S delay bit and is ignored.
  - Slots 1..`DATA_W` shift SDATA into `shreg` MSB-first (`shreg` ← {`shreg`[`DATA_W`-2:0], sdata}).
  - Slots above `DATA_W` (e.g. 25..31 in 32-bit slots) are ignored.
- **Completion:**
  - On the `bclk_rise` that captures slot `DATA_W` while `locked` = 1:
    - `au_data` ← the completed shift value;
    - `ws` ← `lrck_q`;
    - `au_vld` = 1 in the next cycle.
- **States:**
  - UNLOCKED (after reset): no output is produced. The first LRCK change moves the block to LOCKED and sets `locked` = 1. That half-frame is captured normally.
  - LOCKED: normal operation. There is no return to UNLOCKED except through reset.
- **Frame error:**
  - Trigger: in LOCKED, an LRCK change arrives while the running half-frame has `slot` < `DATA_W`.
  - Response: `frame_err` pulses, the partial word is discarded, `au_vld` does not pulse, and capture restarts at slot 0 for the new channel.
- **Reset:**
  - Applied on any `sys_clk` edge with `sys_rst` = 1, including mid-word.
  - Resets to 0: `au_data`, `ws`, `au_vld`, `frame_err`, `locked`, `slot`, `shreg` and `lrck_q`.
  - Also resets the synchronizer chains to 0.
  - Any partial word in progress is lost.

## Timing
- Latency from the external BCLK rising edge of the LSB to the `au_vld` pulse is `SYNC_STAGES` + 2 `sys_clk` cycles (±1 for edge-sampling uncertainty).
  - `SYNC_STAGES` cycles: synchronizer.
  - 1 cycle: edge detect and capture.
  - 1 cycle: output register.
- `au_vld` and `frame_err` are each exactly 1 cycle wide and are never asserted together.
- `au_data` and `ws` change only in the cycle where `au_vld` = 1, and are stable otherwise.
- Maximum rate is one `au_vld` per half-frame. At 48 kHz with 64·fs BCLK that is 96 k strobes/s, i.e. about 520 `sys_clk` cycles apart.
- An LRCK change and the slot-`DATA_W` capture can never land on the same `bclk_rise`, because they are different slots. No arbitration is needed.
- The `slot` counter saturates at 63, so it cannot wrap during a long LRCK-stuck condition. Completion fires once per half-frame at most.

## Structure
- Package `i2s_pkg` holds:
  - `DATA_W_DEF` = 24;
  - `SLOT_W` = 6;
  - `SLOT_MAX` = 63;
  - channel constants `CH_LEFT` = 0 and `CH_RIGHT` = 1.
- Sub-module `i2s_sync`: a parameterized `SYNC_STAGES` synchronizer plus previous-value register.
  - Instantiated three times.
  - The BCLK instance exports the `rise` output.
- The top level contains the slot counter, lock state, shift register and output registers.

## Test plan
- Reset, then stream 64·fs frames: L = 24'h123456, R = 24'hABCDEF.
  - `au_vld` pulses alternate `ws` 0/1 with the matching data.
  - `locked` rises on the first LRCK edge.
  - Nothing is output before that edge.
- 32-bit slots with trailing garbage bits 1 in slots 25..31, data 24'h800001.
  - `au_data` = 24'h800001; the extra bits are ignored.
- Truncated half-frame: LRCK toggles after 10 bits.
  - One `frame_err` pulse, no `au_vld` for that half-frame.
  - The next full word 24'h00FFFF is received correctly.
- Assert `sys_rst` for 1 cycle mid-word, then resume the stream.
  - All outputs are 0 and `locked` = 0.
  - The first valid sample appears only after the next LRCK edge plus 24 bits.
- Maximum BCLK = `sys_clk`/4 with random samples, checked against a reference model over 1000 half-frames.
  - Zero mismatches.
  - Latency is within `SYNC_STAGES` + 2 ±1 cycles.
- Hold LRCK static for 100 BCLKs.
  - Exactly one `au_vld`.
  - `slot` saturates at 63 with no further strobes.
